phj_phase_sequencer: RTL
========================

Name: phj_phase_sequencer

Overview:
Top-level controller for the partitioned-hash-join stream front end.
- Sequences the 512-bit-to-8-lane stream converter through IDLE, BUILD, drain, PROBE and DONE.
- Holds probe issue until every build lane has drained into its hash table.
- Generates the in-order retired serial number `curr_sn`, which throttles the converter's in-flight probe window.
- Sits beside the converter and between the probe result collectors and the host config registers.

Parameters:
- LANES, 8, number of tuple lanes/partitions; must equal converter lane count.
- SN_W, 32, serial number width.
- WINDOW, 8, reorder window depth; power of two; must be ≥ converter MAX_IN_TRANSIT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  single-cycle pulse; begins a join run.
- cfg_probe_lines  in  SN_W  number of probe input lines expected for this run; latched on accepted cfg_start.
- busy  out  1  high while phase ≠ IDLE and ≠ DONE.
- done  out  1  high while in DONE.
- phase  out  3  0=IDLE, 1=BUILD, 2=BDRAIN, 3=PROBE, 4=DONE.
- conv_resetn  out  1  active-low reset driven to the converter.
- conv_last_build  in  LANES  converter per-lane build last flags.
- conv_last_probe  in  LANES  converter per-lane probe last flags.
- build_ack  in  LANES  per-lane level: hash-table insert pipeline empty.
- probe_gate  out  1  top level ANDs this into every converter out_ready_PROBE bit.
- probe_ret_valid  in  1  a probe line finished all lanes.
- probe_ret_sn  in  SN_W  serial number of the finished line (low 32 bits of converter serialnum).
- curr_sn  out  SN_W  count of in-order retired probe lines; drives converter curr_sn.
- err_sn  out  1  sticky protocol error flag.

Behaviour:
- Reset: all outputs below are registered and take these values on reset; any in-flight run is abandoned.
  - phase=IDLE, busy=0, done=0, conv_resetn=0, probe_gate=0, curr_sn=0, err_sn=0.
  - Internal retire bitmap[WINDOW]=0, lines_q=0.
- IDLE:
  - conv_resetn=0.
  - On cfg_start: lines_q←cfg_probe_lines, bitmap←0, curr_sn←0, err_sn←0, go to BUILD.
- BUILD:
  - conv_resetn stays 0 during the first BUILD cycle, then 1.
  - Go to BDRAIN on the cycle after &conv_last_build is sampled high.
- BDRAIN:
  - Go to PROBE when &build_ack is sampled high.
  - probe_gate is asserted one cycle after entering PROBE; no probe tuple may leave the converter earlier.
- PROBE:
  - probe_gate=1.
  - Accepting a return:
    - Compute offset = probe_ret_sn − curr_sn, mod 2^SN_W.
    - Valid when offset < WINDOW and bitmap[probe_ret_sn mod WINDOW]=0; then set that bit.
    - Otherwise set err_sn=1 and drop the return.
  - Retire, at most one per cycle: if the registered bitmap[curr_sn mod WINDOW]=1, clear it and curr_sn←curr_sn+1. curr_sn wraps at 2^SN_W.
  - Latency: a return with sn==curr_sn increments curr_sn 2 cycles after probe_ret_valid.
  - Simultaneous events: a set and a clear on the same bit index in one cycle are impossible (offset 0 is the clear target only after it was set); if they coincide, the set wins.
- Exit from PROBE:
  - Go to DONE when curr_sn==lines_q and &conv_last_probe are both high in the same sampled cycle.
  - lines_q=0 is legal: exit on &conv_last_probe alone.
- DONE:
  - done=1, probe_gate=0, conv_resetn=1. Converter state is kept for readout.
  - On cfg_start: same actions as the IDLE start, go to BUILD.
- cfg_start while in BUILD, BDRAIN or PROBE is ignored and does not set err_sn.
- probe_ret_valid outside PROBE sets err_sn and is dropped.
- err_sn never halts the FSM; it clears only on reset or an accepted cfg_start.
- busy and done are decoded from the registered phase (0-cycle after phase).

Decomposition:
- Package phj_pkg:
  - phase_t enum (IDLE..DONE with the codes above).
  - PHJ_LANES, PHJ_SN_W constants shared with the converter.
- Sub-module sn_reorder_window: holds the bitmap, the offset check and the in-order retire counter.
  - Ports: clk, reset, clear, ret_valid, ret_sn, curr_sn, err.
  - Reused by later result-merge stages.

Test Plan:
- Normal run:
  - Stimulus: reset, cfg_start with lines=4; conv_last_build=FF at cycle 10; build_ack=FF at cycle 15; returns sn 0,1,2,3 in order; conv_last_probe=FF.
  - Required: phase 1→2→3→4; probe_gate rises at cycle 17; curr_sn reaches 4; done=1.
- Out-of-order returns:
  - Stimulus: in PROBE, returns sn 2, 1, 0 on consecutive cycles.
  - Required: curr_sn stays 0 until sn 0 arrives, then steps 1, 2, 3 on consecutive cycles; err_sn=0.
- Window violation:
  - Stimulus: curr_sn=0, WINDOW=8; return sn 8, then duplicate sn 3, 3.
  - Required: err_sn=1 after sn 8; the second sn 3 is dropped; curr_sn unaffected by either.
- Drain gating:
  - Stimulus: build_ack=7F held for 50 cycles after conv_last_build=FF.
  - Required: phase stays 2; probe_gate=0 throughout; PROBE is entered 1 cycle after build_ack=FF.
- Zero lines and restart:
  - Stimulus: lines=0, conv_last_probe=FF in PROBE, then cfg_start in DONE.
  - Required: DONE is reached with curr_sn=0; after restart, conv_resetn=0 for exactly 1 cycle and curr_sn=0.
- Reset mid-PROBE:
  - Stimulus: reset asserted with curr_sn=5.
  - Required: next cycle phase=0, curr_sn=0, conv_resetn=0, probe_gate=0, done=0.

Source files
------------

// File: rtl/phj_pkg.sv
// Shared types and constants for the partitioned-hash-join front end.
// Lane count and serial-number width must track the stream converter.
package phj_pkg;

    localparam int PHJ_LANES  = 8;
    localparam int PHJ_SN_W   = 32;
    localparam int PHJ_WINDOW = 8;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_BUILD  = 3'd1,
        PH_BDRAIN = 3'd2,
        PH_PROBE  = 3'd3,
        PH_DONE   = 3'd4
    } phase_t;

endpackage

// File: rtl/sn_reorder_window.sv
// Out-of-order completion tracker: marks returned serial numbers in a bitmap and
// retires them in order, one per cycle; a return with sn==curr_sn retires 2 cycles later.
module sn_reorder_window #(
    parameter int SN_W   = 32,
    parameter int WINDOW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            ret_valid,
    input  logic [SN_W-1:0] ret_sn,
    output logic [SN_W-1:0] curr_sn,
    output logic            err
);

    localparam int IDX_W = $clog2(WINDOW);

    logic [WINDOW-1:0] bitmap_q, bitmap_d;
    logic [SN_W-1:0]   curr_q, curr_d;
    logic [SN_W-1:0]   offset;
    logic [IDX_W-1:0]  set_idx;
    logic [IDX_W-1:0]  ret_idx;
    logic              accept;

    assign offset  = ret_sn - curr_q;
    assign set_idx = ret_sn[IDX_W-1:0];
    assign ret_idx = curr_q[IDX_W-1:0];
    assign accept  = ret_valid && (offset < SN_W'(WINDOW)) && !bitmap_q[set_idx];
    assign err     = ret_valid && !accept;

    always_comb begin
        bitmap_d = bitmap_q;
        curr_d   = curr_q;
        if (bitmap_q[ret_idx]) begin
            bitmap_d[ret_idx] = 1'b0;
            curr_d            = curr_q + 1'b1;
        end
        // Set is applied after the clear so it wins on a shared index.
        if (accept) begin
            bitmap_d[set_idx] = 1'b1;
        end
        if (clear) begin
            bitmap_d = '0;
            curr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap_q <= '0;
            curr_q   <= '0;
        end else begin
            bitmap_q <= bitmap_d;
            curr_q   <= curr_d;
        end
    end

    assign curr_sn = curr_q;

endmodule

// File: rtl/phj_phase_sequencer.sv
// Join-run controller: IDLE -> BUILD -> BDRAIN -> PROBE -> DONE with converter reset,
// probe gating and in-order retirement; all control outputs are registered.
module phj_phase_sequencer
    import phj_pkg::*;
#(
    parameter int LANES  = PHJ_LANES,
    parameter int SN_W   = PHJ_SN_W,
    parameter int WINDOW = PHJ_WINDOW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [SN_W-1:0]  cfg_probe_lines,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase,
    output logic             conv_resetn,
    input  logic [LANES-1:0] conv_last_build,
    input  logic [LANES-1:0] conv_last_probe,
    input  logic [LANES-1:0] build_ack,
    output logic             probe_gate,
    input  logic             probe_ret_valid,
    input  logic [SN_W-1:0]  probe_ret_sn,
    output logic [SN_W-1:0]  curr_sn,
    output logic             err_sn
);

    phase_t          phase_q, phase_d;
    logic [SN_W-1:0] lines_q, lines_d;
    logic            conv_resetn_q, conv_resetn_d;
    logic            probe_gate_q, probe_gate_d;
    logic            err_q, err_d;
    logic            start_ok;
    logic            win_valid;
    logic            win_err;
    logic [SN_W-1:0] win_curr_sn;

    assign start_ok  = cfg_start && (phase_q == PH_IDLE || phase_q == PH_DONE);
    assign win_valid = probe_ret_valid && (phase_q == PH_PROBE);

    sn_reorder_window #(
        .SN_W   (SN_W),
        .WINDOW (WINDOW)
    ) u_window (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .ret_valid (win_valid),
        .ret_sn    (probe_ret_sn),
        .curr_sn   (win_curr_sn),
        .err       (win_err)
    );

    always_comb begin
        phase_d = phase_q;
        lines_d = lines_q;
        case (phase_q)
            PH_IDLE, PH_DONE: begin
                if (cfg_start) begin
                    phase_d = PH_BUILD;
                    lines_d = cfg_probe_lines;
                end
            end
            PH_BUILD:  if (&conv_last_build) phase_d = PH_BDRAIN;
            PH_BDRAIN: if (&build_ack) phase_d = PH_PROBE;
            PH_PROBE:  if ((win_curr_sn == lines_q) && (&conv_last_probe)) phase_d = PH_DONE;
            default:   phase_d = PH_IDLE;
        endcase

        // Converter is held in reset through the first BUILD cycle of every run.
        conv_resetn_d = !((phase_d == PH_IDLE) || (phase_d == PH_BUILD && phase_q != PH_BUILD));
        probe_gate_d  = (phase_q == PH_PROBE) && (phase_d == PH_PROBE);

        err_d = err_q || win_err || (probe_ret_valid && phase_q != PH_PROBE);
        if (start_ok) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= PH_IDLE;
            lines_q       <= '0;
            conv_resetn_q <= 1'b0;
            probe_gate_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            lines_q       <= lines_d;
            conv_resetn_q <= conv_resetn_d;
            probe_gate_q  <= probe_gate_d;
            err_q         <= err_d;
        end
    end

    assign phase       = phase_q;
    assign busy        = (phase_q != PH_IDLE) && (phase_q != PH_DONE);
    assign done        = (phase_q == PH_DONE);
    assign conv_resetn = conv_resetn_q;
    assign probe_gate  = probe_gate_q;
    assign curr_sn     = win_curr_sn;
    assign err_sn      = err_q;

endmodule
